// File: rtl/mux4_way16.sv
// ---------------------------------------------------------------------------
// mux4_way16 -- four-way WIDTH-bit multiplexer with a registered copy.
//
// Purpose:
//   Selects one of four data words combinationally (out). An enabled capture
//   register (out_q) samples that word on the rising clock edge. out_valid
//   flags that out_q holds a captured value.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous active-high reset of out_q/out_valid
//   d0..d3     in   WIDTH  data words selected by sel = 00/01/10/11
//   sel        in   2      selection code
//   en         in   1      capture enable for out_q
//   out        out  WIDTH  combinational mux result (ignores clk/rst/en)
//   out_q      out  WIDTH  registered mux result
//   out_valid  out  1      high once out_q holds a captured value
// ---------------------------------------------------------------------------
module mux4_way16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] r_out_q;
  logic             r_out_valid;

  // Select decode. All four codes are covered; the default only fires for an
  // unknown sel in simulation and drives X, which synthesis treats as a
  // don't-care, so the decode stays a full case with no latch.
  always_comb begin
    w_mux = {WIDTH{1'bx}};
    case (sel)
      2'b00:   w_mux = d0;
      2'b01:   w_mux = d1;
      2'b10:   w_mux = d2;
      2'b11:   w_mux = d3;
      default: w_mux = {WIDTH{1'bx}};
    endcase
  end

  assign out = w_mux;

  // Capture register: reset wins over enable, otherwise load on en or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q     <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (en) begin
      r_out_q     <= w_mux;
      r_out_valid <= 1'b1;
    end else begin
      r_out_q     <= r_out_q;
      r_out_valid <= r_out_valid;
    end
  end

  assign out_q     = r_out_q;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux4_way16.sv
// ---------------------------------------------------------------------------
// tb_mux4_way16 -- directed self-checking bench for mux4_way16.
// Inputs change 1 time unit after a rising edge; registered outputs are
// sampled 1 time unit after the edge, combinational ones 1 unit after the
// input change.
// ---------------------------------------------------------------------------
module tb_mux4_way16;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [1:0]       sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;

  int n_checks;
  int n_fail;

  mux4_way16 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .sel       (sel),
    .en        (en),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    en  = 1'b0;
    sel = 2'b00;
    d0  = 16'h0000;
    d1  = 16'h0000;
    d2  = 16'h0000;
    d3  = 16'h0000;

    // Reset state
    tick();
    chk ("reset_out_q",     out_q,     16'h0000);
    chk1("reset_out_valid", out_valid, 1'b0);
    rst = 1'b0;

    // Combinational selection, same time step as each sel change
    d0 = 16'b0001001000110100;
    d1 = 16'b1001100001110110;
    d2 = 16'b1010101010101010;
    d3 = 16'b0101010101010101;
    sel = 2'b00; #1 chk("sel00_out", out, 16'h1234);
    sel = 2'b01; #1 chk("sel01_out", out, 16'h9876);
    sel = 2'b10; #1 chk("sel10_out", out, 16'hAAAA);
    sel = 2'b11; #1 chk("sel11_out", out, 16'h5555);
    chk1("no_capture_en0_valid", out_valid, 1'b0);

    // Reset for one cycle with en=1; out still shows the selected input
    rst = 1'b1;
    en  = 1'b1;
    sel = 2'b10;
    tick();
    chk ("rst_en_out_q",     out_q,     16'h0000);
    chk1("rst_en_out_valid", out_valid, 1'b0);
    chk ("rst_out_passthru", out,       16'hAAAA);

    // Release reset, capture d2
    rst = 1'b0;
    tick();
    chk ("cap_d2_out_q",     out_q,     16'hAAAA);
    chk1("cap_d2_out_valid", out_valid, 1'b1);
    sel = 2'b11;
    #1;
    chk("sel11_immediate_out", out,   16'h5555);
    chk("out_q_before_edge",   out_q, 16'hAAAA);
    tick();
    chk("cap_d3_out_q", out_q, 16'h5555);

    // en=0: out tracks inputs, registers hold
    en  = 1'b0;
    sel = 2'b00;
    d0  = 16'hBEEF;
    #1 chk("en0_out_track", out, 16'hBEEF);
    tick();
    chk ("en0_hold_out_q",     out_q,     16'h5555);
    chk1("en0_hold_out_valid", out_valid, 1'b1);
    d3 = 16'hC3C3;
    tick();
    chk("en0_hold2_out_q", out_q, 16'h5555);

    // sel=01: toggling non-selected inputs must not disturb out
    sel = 2'b01;
    #1 chk("sel01_base", out, 16'h9876);
    d0 = 16'hFFFF; #1 chk("d0_toggle_out", out, 16'h9876);
    d2 = 16'h0000; #1 chk("d2_toggle_out", out, 16'h9876);
    d3 = 16'h0F0F; #1 chk("d3_toggle_out", out, 16'h9876);
    d1 = 16'h1357; #1 chk("d1_change_out", out, 16'h1357);

    // Capture uses sel as sampled at the edge
    en  = 1'b1;
    sel = 2'b11;
    tick();
    chk("cap_sel_at_edge", out_q, 16'h0F0F);

    // Reset and enable on the same edge: reset wins
    rst = 1'b1;
    en  = 1'b1;
    tick();
    chk ("rst_wins_out_q",     out_q,     16'h0000);
    chk1("rst_wins_out_valid", out_valid, 1'b0);

    // After reset with en=0 nothing is captured
    rst = 1'b0;
    en  = 1'b0;
    tick();
    chk1("post_rst_en0_valid", out_valid, 1'b0);
    chk ("post_rst_en0_out_q", out_q,     16'h0000);

    // First enabled edge after reset sets out_valid
    en  = 1'b1;
    sel = 2'b00;
    tick();
    chk1("first_en_valid", out_valid, 1'b1);
    chk ("first_en_out_q", out_q,     16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_way16.md
MUX4_WAY16 -- requirements
Module: mux4_way16

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of every data input and output.

Ports:
REQ-002 The block SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have d0, input, WIDTH bits: data selected when sel=00.
REQ-005 The block SHALL have d1, input, WIDTH bits: data selected when sel=01.
REQ-006 The block SHALL have d2, input, WIDTH bits: data selected when sel=10.
REQ-007 The block SHALL have d3, input, WIDTH bits: data selected when sel=11.
REQ-008 The block SHALL have sel, input, 2 bits: selection code.
REQ-009 The block SHALL have en, input, 1 bit: capture enable for the registered output.
REQ-010 The block SHALL have out, output, WIDTH bits: combinational mux result.
REQ-011 The block SHALL have out_q, output, WIDTH bits: registered mux result.
REQ-012 The block SHALL have out_valid, output, 1 bit: high once out_q holds a captured value.

Function
REQ-013 out SHALL equal d0, d1, d2 or d3 for sel = 00, 01, 10 or 11 respectively, bit-for-bit across all WIDTH bits.
REQ-014 out SHALL be purely combinational with zero latency, and SHALL not depend on clk, rst or en.
REQ-015 A change on sel or the selected data input SHALL propagate to out in the same time step, with no clock edge required.
REQ-016 out SHALL follow only the selected input; changes on non-selected inputs SHALL have no effect on out.
REQ-017 On a rising clk edge with rst=0 and en=1, out_q SHALL load the current value of out and out_valid SHALL be set to 1.
REQ-018 On a rising clk edge with rst=0 and en=0, out_q and out_valid SHALL hold their values.
REQ-019 out_q SHALL lag out by exactly one clock cycle when en is held high.
REQ-020 If sel changes in the same cycle as a capture edge, out_q SHALL take the value selected by sel as sampled at that edge.
REQ-021 The block SHALL perform no arithmetic, truncation or extension; every output bit SHALL map directly from the same bit of the selected input.
REQ-022 If sel contains X or Z, out SHALL be driven to X for simulation.
REQ-023 Synthesised logic SHALL treat the sel decode as a full case, with no latches inferred.

Reset
REQ-024 On a rising clk edge with rst=1, out_q SHALL become all zeros and out_valid SHALL become 0.
REQ-025 rst SHALL take priority over en.
REQ-026 rst SHALL have no effect on out, which continues to reflect the inputs during reset.
REQ-027 If rst is asserted mid-operation, the registered state SHALL be discarded at that edge.
REQ-028 After rst is deasserted, the first edge with en=1 SHALL set out_valid to 1.

Verification
REQ-029 Scenario: apply d0=0001001000110100, d1=1001100001110110, d2=1010101010101010, d3=0101010101010101 and step sel through 00, 01, 10, 11 -> out SHALL equal d0, d1, d2, d3 respectively, at the same time step as each sel change.
REQ-030 Scenario: assert rst for 1 cycle with en=1 -> out_q SHALL equal 0 and out_valid SHALL equal 0 at that edge, while out still shows the selected input.
REQ-031 Scenario: release rst, hold en=1, sel=10 -> after 1 edge out_q SHALL equal 1010101010101010 and out_valid SHALL equal 1; then change sel to 11 -> out SHALL change immediately and out_q SHALL equal 0101010101010101 after the next edge.
REQ-032 Scenario: set en=0, then change sel and the data inputs -> out SHALL track the inputs while out_q and out_valid hold.
REQ-033 Scenario: with sel=01, toggle d0, d2 and d3 -> out SHALL remain equal to d1.
REQ-034 Scenario: assert rst=1 and en=1 on the same edge -> reset SHALL win, giving out_q=0 and out_valid=0.
